// File: rtl/uart_tx_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pushes while full and pops while empty are dropped.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL registers, TX FIFO,
// serializer and a transmitter-drained interrupt.
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    input  logic [3:0]  mem_en,
    input  logic        mem_wea,
    input  logic        mem_rea,
    output logic [31:0] mem_dout,
    output logic        mem_hold,
    output logic        tx,
    output logic        uart_IRQ
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          sel;
    logic [1:0]    off;
    logic          wr_lane0;
    logic          txdata_wr;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          irq_en;
    logic [31:0]   rdata;

    tx_state_t     state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d;
    logic          irq_d;
    logic          baud_tc;

    // Bits of the bus that this block never looks at.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{mem_din[31:8], mem_addr[1:0], mem_en[3:1]};

    assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign off       = mem_addr[3:2];
    assign wr_lane0  = sel && mem_wea && mem_en[0];
    assign txdata_wr = wr_lane0 && (off == OFF_TXDATA);
    // A store to a full FIFO stalls the pipeline until a slot frees up.
    assign fifo_push = txdata_wr && !fifo_full && !Rst;
    assign mem_hold  = txdata_wr && fifo_full && !Rst;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mem_din[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rdata = '0;
        case (off)
            OFF_STATUS: begin
                rdata[STAT_FULL]                        = fifo_full;
                rdata[STAT_EMPTY]                       = fifo_empty;
                rdata[STAT_BUSY]                        = (state_q != IDLE);
                rdata[STAT_COUNT_LSB +: 8]              = 8'(fifo_count);
            end
            OFF_CTRL: rdata[0] = irq_en;
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            irq_en   <= 1'b0;
            mem_dout <= '0;
        end else begin
            if (wr_lane0 && (off == OFF_CTRL)) irq_en <= mem_din[0];
            mem_dout <= (sel && mem_rea) ? rdata : '0;
        end
    end

    assign baud_tc = (baud_q == 16'(CLK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx and uart_IRQ are registered from next-state values so they line
        // up with the state register rather than lagging it by a cycle.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        irq_d = irq_en && fifo_empty && !fifo_push && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
            uart_IRQ <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
            uart_IRQ <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4, base 0x8000.
module tb_uart_tx_mmio;

    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] BASE       = 32'h0000_8000;

    logic        clk;
    logic        Rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_en;
    logic        mem_wea;
    logic        mem_rea;
    logic [31:0] mem_dout;
    logic        mem_hold;
    logic        tx;
    logic        uart_IRQ;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_tx_mmio #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .Rst      (Rst),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_en   (mem_en),
        .mem_wea  (mem_wea),
        .mem_rea  (mem_rea),
        .mem_dout (mem_dout),
        .mem_hold (mem_hold),
        .tx       (tx),
        .uart_IRQ (uart_IRQ)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver tasks: all start and end at posedge+1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] en, output int hold_cyc);
        hold_cyc = 0;
        mem_addr = addr;
        mem_din  = data;
        mem_en   = en;
        mem_wea  = 1'b1;
        #1;
        while (mem_hold === 1'b1 && hold_cyc < 1000) begin
            hold_cyc++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        mem_wea = 1'b0;
        mem_en  = 4'b0000;
    endtask

    task automatic send(input logic [7:0] b, output int hold_cyc);
        exp_q.push_back(b);
        store(BASE, {24'h0, b}, 4'b0001, hold_cyc);
    endtask

    task automatic read(input logic [31:0] addr, output logic [31:0] data);
        mem_addr = addr;
        mem_rea  = 1'b1;
        #1;
        check("read_hold", {31'b0, mem_hold}, 32'd0);
        @(posedge clk);
        #1;
        mem_rea = 1'b0;
        #1;
        data = mem_dout;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: receive one frame and compare to the head of exp_q
    task automatic rx_frame(input bit chk_gap);
        int highs;
        logic [7:0] b;
        logic [9:0] fr;
        highs = 0;
        while (highs < 500) begin
            @(posedge clk);
            #2;
            if (tx === 1'b0) break;
            highs++;
        end
        check("rx_start", {31'b0, tx}, 32'd0);
        if (chk_gap) check("frame_gap", highs, 32'd1);
        check("rx_expected", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 32'd1);
        b  = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        fr = {1'b1, b, 1'b0};
        for (int k = 1; k < 10 * CLK_DIV; k++) begin
            @(posedge clk);
            #2;
            check("rx_bit", {31'b0, tx}, {31'b0, fr[k / CLK_DIV]});
            if (k == 20 || k == 10 * CLK_DIV - 1)
                check("irq_in_frame", {31'b0, uart_IRQ}, 32'd0);
        end
    endtask

    task automatic burst_stores();
        int h;
        logic [31:0] d;
        logic [7:0] bytes [6];
        bytes = '{8'h01, 8'h80, 8'hC3, 8'h5A, 8'hFF, 8'h00};
        for (int i = 0; i < 5; i++) begin
            send(bytes[i], h);
            check("burst_nohold", h, 32'd0);
        end
        // One byte in the shifter plus four buffered: the sixth store waits
        // out the remainder of frame 1 (38 cycles) until the next pop.
        send(bytes[5], h);
        check("burst_hold_cycles", h, 32'd38);
        read(BASE + 32'h4, d);
        check("burst_status_full", d, 32'h0000_0405);
    endtask

    task automatic burst_rx();
        rx_frame(1'b0);
        for (int i = 1; i < 6; i++) rx_frame(1'b1);
    endtask

    initial begin
        logic [31:0] d;
        int h;
        int lows;
        Rst      = 1'b1;
        mem_addr = '0;
        mem_din  = '0;
        mem_en   = '0;
        mem_wea  = 1'b0;
        mem_rea  = 1'b0;
        tick();
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_hold", {31'b0, mem_hold}, 32'd0);
        check("rst_irq", {31'b0, uart_IRQ}, 32'd0);
        check("rst_dout", mem_dout, 32'd0);
        tick();
        Rst = 1'b0;

        // Idle after reset
        repeat (20) tick();
        check("idle_tx", {31'b0, tx}, 32'd1);
        check("idle_hold", {31'b0, mem_hold}, 32'd0);
        check("idle_irq", {31'b0, uart_IRQ}, 32'd0);
        read(BASE + 32'h4, d);
        check("idle_status", d, 32'h0000_0002);
        #1;
        check("dout_cleared", mem_dout, 32'd0);
        tick();

        // Single frame 0x55
        send(8'h55, h);
        check("single_nohold", h, 32'd0);
        rx_frame(1'b0);
        lows = 0;
        repeat (12) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("after_frame_idle", lows, 32'd0);

        // Back-to-back burst with FIFO-full stall
        fork
            burst_stores();
            burst_rx();
        join
        tick();
        read(BASE + 32'h4, d);
        check("burst_drained", d, 32'h0000_0002);

        // Interrupt on drain
        store(BASE + 32'h8, 32'h1, 4'b0001, h);
        tick();
        tick();
        check("irq_idle_enabled", {31'b0, uart_IRQ}, 32'd1);
        read(BASE + 32'h8, d);
        check("ctrl_readback", d, 32'h0000_0001);
        send(8'hA5, h);
        check("irq_drop_on_push", {31'b0, uart_IRQ}, 32'd0);
        rx_frame(1'b0);
        tick();
        check("irq_after_stop", {31'b0, uart_IRQ}, 32'd1);
        send(8'h3C, h);
        check("irq_drop_on_push2", {31'b0, uart_IRQ}, 32'd0);
        rx_frame(1'b0);
        tick();
        check("irq_after_stop2", {31'b0, uart_IRQ}, 32'd1);

        // Reset during DATA bit 3 with two bytes queued
        send(8'h11, h);
        send(8'h22, h);
        send(8'h33, h);
        lows = 0;
        while (lows < 500) begin
            @(posedge clk);
            #2;
            if (tx === 1'b0) break;
            lows++;
        end
        check("rst_mid_start", {31'b0, tx}, 32'd0);
        repeat (4 * CLK_DIV) @(posedge clk);
        #2;
        Rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", {31'b0, tx}, 32'd1);
        check("rst_mid_hold", {31'b0, mem_hold}, 32'd0);
        check("rst_mid_irq", {31'b0, uart_IRQ}, 32'd0);
        Rst = 1'b0;
        exp_q.delete();
        read(BASE + 32'h4, d);
        check("rst_mid_status", d, 32'h0000_0002);
        lows = 0;
        repeat (60) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("rst_no_frames", lows, 32'd0);
        check("rst_irq_en_clr", {31'b0, uart_IRQ}, 32'd0);

        // Unselected, reserved and lane-gated stores
        store(32'h0000_9000, 32'hAA, 4'b0001, h);
        check("unsel_hold", h, 32'd0);
        store(BASE + 32'hC, 32'h77, 4'b0001, h);
        check("reserved_hold", h, 32'd0);
        store(BASE, 32'h66, 4'b0010, h);
        check("lane_hold", h, 32'd0);
        read(BASE + 32'h4, d);
        check("ignored_status", d, 32'h0000_0002);
        read(32'h0000_9000, d);
        check("unsel_read", d, 32'd0);
        read(BASE + 32'hC, d);
        check("reserved_read", d, 32'd0);
        read(BASE, d);
        check("txdata_read", d, 32'd0);
        lows = 0;
        repeat (50) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("ignored_no_frames", lows, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
